multi_cnt_ctrl: RTL

MULTI_CNT_CTRL -- requirements
Module: multi_cnt_ctrl

---
 rtl/multi_cnt_ctrl_pkg.sv | 30 +++
 rtl/multi_cnt_channel.sv | 119 +++++++++++
 rtl/multi_cnt_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/multi_cnt_ctrl_pkg.sv
// Shared register map, CTRL bit positions and mode encoding for the multi-channel counter block.
package multi_cnt_ctrl_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_THR    = 4'h4;
    localparam logic [3:0] OFF_VAL    = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int unsigned CH_STRIDE  = 16;
    localparam logic [8:0]  IRQ_OFFSET = 9'h100;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_CLR_BIT    = 1;
    localparam int unsigned CTRL_MODE_BIT   = 2;
    localparam int unsigned CTRL_IRQ_EN_BIT = 3;

    typedef enum logic {
        ModeOneShot    = 1'b0,
        ModeAutoReload = 1'b1
    } cnt_mode_e;

    // Register selected by address bits [3:2] inside a channel block.
    typedef enum logic [1:0] {
        RegCtrl   = 2'd0,
        RegThr    = 2'd1,
        RegVal    = 2'd2,
        RegStatus = 2'd3
    } reg_sel_e;

endpackage

// File: rtl/multi_cnt_channel.sv
// One counter channel: count, CTRL, THR and sticky STATUS with terminal-count handling.
module multi_cnt_channel
    import multi_cnt_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ctrl_we_i,
    input  logic             thr_we_i,
    input  logic             status_we_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [31:0]      ctrl_rdata_o,
    output logic [31:0]      thr_rdata_o,
    output logic [31:0]      status_rdata_o,
    output logic             tc_o,
    output logic             irq_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic             status_q, status_d;
    cnt_mode_e        mode_q, mode_d;

    logic clr;
    logic at_thr;
    logic tc;

    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

    always_comb begin
        clr      = ctrl_we_i && wdata_i[CTRL_CLR_BIT];
        at_thr   = (cnt_q == thr_q);
        // A clear in the same cycle swallows the terminal count entirely.
        tc       = en_q && at_thr && !clr;

        cnt_d    = cnt_q;
        thr_d    = thr_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        mode_d   = mode_q;
        status_d = status_q;

        if (clr) begin
            cnt_d = '0;
        end else if (en_q) begin
            if (!at_thr) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (mode_q == ModeAutoReload) begin
                cnt_d = '0;
            end
        end

        if (tc && (mode_q == ModeOneShot)) begin
            en_d = 1'b0;
        end

        if (ctrl_we_i) begin
            en_d     = wdata_i[CTRL_EN_BIT];
            mode_d   = cnt_mode_e'(wdata_i[CTRL_MODE_BIT]);
            irq_en_d = wdata_i[CTRL_IRQ_EN_BIT];
        end

        if (thr_we_i) begin
            thr_d = wdata_i[CNT_W-1:0];
        end

        // Ordering gives hardware set priority over software clear.
        if (status_we_i && wdata_i[0]) begin
            status_d = 1'b0;
        end
        if (clr) begin
            status_d = 1'b0;
        end
        if (tc) begin
            status_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            thr_q    <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            mode_q   <= ModeOneShot;
            status_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            thr_q    <= thr_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            mode_q   <= mode_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        ctrl_rdata_o                   = '0;
        ctrl_rdata_o[CTRL_EN_BIT]      = en_q;
        ctrl_rdata_o[CTRL_MODE_BIT]    = mode_q;
        ctrl_rdata_o[CTRL_IRQ_EN_BIT]  = irq_en_q;
        thr_rdata_o                    = '0;
        thr_rdata_o[CNT_W-1:0]         = thr_q;
        status_rdata_o                 = '0;
        status_rdata_o[0]              = status_q;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc;
    assign irq_o = status_q && irq_en_q;

endmodule

// File: rtl/multi_cnt_ctrl.sv
// Multi-channel counter controller: register decode, per-channel write strobes and read-back path.
module multi_cnt_ctrl
    import multi_cnt_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    reg_req_i,
    input  logic                    reg_we_i,
    input  logic [8:0]              reg_addr_i,
    input  logic [31:0]             reg_wdata_i,
    output logic                    reg_gnt_o,
    output logic                    reg_rvalid_o,
    output logic [31:0]             reg_rdata_o,
    output logic                    reg_err_o,
    output logic [NUM_CH*CNT_W-1:0] cnt_val_o,
    output logic [NUM_CH-1:0]       cnt_tc_o,
    output logic [NUM_CH-1:0]       irq_o
);

    logic [CNT_W-1:0] cnt        [NUM_CH];
    logic [31:0]      ctrl_rd    [NUM_CH];
    logic [31:0]      thr_rd     [NUM_CH];
    logic [31:0]      status_rd  [NUM_CH];
    logic [NUM_CH-1:0] ctrl_we, thr_we, status_we;

    logic [3:0]  ch_idx;
    reg_sel_e    reg_sel;
    logic        irq_hit;
    logic        ch_hit;
    logic        wr;
    logic [31:0] ch_rdata;

    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic unused_addr;
    assign unused_addr = ^reg_addr_i[1:0];

    assign reg_gnt_o = 1'b1;

    always_comb begin
        ch_idx  = reg_addr_i[7:4];
        reg_sel = reg_sel_e'(reg_addr_i[3:2]);
        irq_hit = (reg_addr_i[8:2] == IRQ_OFFSET[8:2]);
        ch_hit  = !reg_addr_i[8] && (32'(ch_idx) < NUM_CH);
        wr      = reg_req_i && reg_we_i && ch_hit;

        ctrl_we   = '0;
        thr_we    = '0;
        status_we = '0;
        ch_rdata  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 4'(c)) begin
                ctrl_we[c]   = wr && (reg_sel == RegCtrl);
                thr_we[c]    = wr && (reg_sel == RegThr);
                status_we[c] = wr && (reg_sel == RegStatus);
                unique case (reg_sel)
                    RegCtrl:   ch_rdata = ctrl_rd[c];
                    RegThr:    ch_rdata = thr_rd[c];
                    RegVal:    ch_rdata = 32'(cnt[c]);
                    RegStatus: ch_rdata = status_rd[c];
                endcase
            end
        end
    end

    // Response: writes always return zero data; writes to read-only locations flag an error.
    always_comb begin
        rvalid_d = reg_req_i;
        rdata_d  = '0;
        err_d    = 1'b0;
        if (reg_req_i) begin
            if (irq_hit) begin
                err_d = reg_we_i;
                if (!reg_we_i) begin
                    rdata_d = 32'(irq_o);
                end
            end else if (ch_hit) begin
                err_d = reg_we_i && (reg_sel == RegVal);
                if (!reg_we_i) begin
                    rdata_d = ch_rdata;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign reg_rvalid_o = rvalid_q;
    assign reg_rdata_o  = rdata_q;
    assign reg_err_o    = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        multi_cnt_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .ctrl_we_i      (ctrl_we[g]),
            .thr_we_i       (thr_we[g]),
            .status_we_i    (status_we[g]),
            .wdata_i        (reg_wdata_i),
            .cnt_o          (cnt[g]),
            .ctrl_rdata_o   (ctrl_rd[g]),
            .thr_rdata_o    (thr_rd[g]),
            .status_rdata_o (status_rd[g]),
            .tc_o           (cnt_tc_o[g]),
            .irq_o          (irq_o[g])
        );
        assign cnt_val_o[g*CNT_W +: CNT_W] = cnt[g];
    end

endmodule
